// File: rtl/axi_lite_reg_slave_if.sv
// axi_lite_reg_slave_if: AXI-lite channel bundle (AW/W/B/AR/R) with master and slave views.
interface axi_lite_channel;
  logic        aw_valid, aw_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  logic        w_valid, w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  logic        b_valid, b_ready;
  logic [1:0]  b_resp;
  logic        ar_valid, ar_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  logic        r_valid, r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;
  modport master (
    output aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, ar_prot, r_ready,
    input  aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
  modport slave (
    input  aw_valid, aw_addr, aw_prot, w_valid, w_data, w_strb, b_ready, ar_valid, ar_addr, ar_prot, r_ready,
    output aw_ready, w_ready, b_valid, b_resp, ar_ready, r_valid, r_data, r_resp
  );
endinterface

// File: rtl/axi_lite_reg_slave.sv
// axi_lite_reg_slave: AXI-lite register file with independent read/write paths.
// Define AXI_LITE_REG_PROT_CHECK_EN to reject unprivileged accesses with SLVERR.
module axi_lite_reg_slave #(
  parameter int          REG_COUNT   = 8,
  parameter logic [31:0] RESET_VALUE = 32'h0
) (
  input  logic                    clk,
  input  logic                    rst,
  axi_lite_channel.slave          master,
  output logic [REG_COUNT*32-1:0] reg_q,
  output logic [REG_COUNT-1:0]    reg_wr
);
  localparam int IW = $clog2(REG_COUNT);
  typedef enum logic {IDLE, RESP} state_e;
  state_e               ws_q, ws_d, rs_q, rs_d;
  logic                 aw_held_q, w_held_q;
  logic [31:0]          aw_addr_q, w_data_q;
  logic [3:0]           w_strb_q;
  logic [1:0]           b_resp_q, b_resp_d, r_resp_q, r_resp_d;
  logic [31:0]          r_data_q, r_data_d;
  logic [REG_COUNT-1:0] wr_q, wr_d;
  logic [31:0]          regs_q [REG_COUNT];
  logic                 aw_fire, w_fire, ar_fire, commit, w_ok, w_in, r_in, w_prot_ok, r_prot_ok;
  logic [31:0]          wa, wd;
  logic [3:0]           ws;
  logic [IW-1:0]        widx, ridx;
`ifdef AXI_LITE_REG_PROT_CHECK_EN
  logic                 aw_priv_q;
  assign w_prot_ok = aw_held_q ? aw_priv_q : master.aw_prot[0];
  assign r_prot_ok = master.ar_prot[0];
`else
  assign w_prot_ok = 1'b1;
  assign r_prot_ok = 1'b1;
`endif
  // Outputs are forced quiet for the whole reset cycle, not just after the edge.
  assign master.aw_ready = !rst && ws_q == IDLE && !aw_held_q;
  assign master.w_ready  = !rst && ws_q == IDLE && !w_held_q;
  assign master.b_valid  = !rst && ws_q == RESP;
  assign master.b_resp   = rst ? 2'b00 : b_resp_q;
  assign master.ar_ready = !rst && rs_q == IDLE;
  assign master.r_valid  = !rst && rs_q == RESP;
  assign master.r_data   = rst ? 32'h0 : r_data_q;
  assign master.r_resp   = rst ? 2'b00 : r_resp_q;
  assign reg_wr          = rst ? '0 : wr_q;
  for (genvar i = 0; i < REG_COUNT; i++) begin : g_out
    assign reg_q[32*i +: 32] = rst ? RESET_VALUE : regs_q[i];
  end
  always_comb begin
    aw_fire  = master.aw_valid && master.aw_ready;
    w_fire   = master.w_valid && master.w_ready;
    ar_fire  = master.ar_valid && master.ar_ready;
    wa       = aw_held_q ? aw_addr_q : master.aw_addr;
    wd       = w_held_q ? w_data_q : master.w_data;
    ws       = w_held_q ? w_strb_q : master.w_strb;
    commit   = ws_q == IDLE && (aw_held_q || aw_fire) && (w_held_q || w_fire);
    widx     = IW'(wa >> 2);
    w_in     = (wa >> 2) < REG_COUNT;
    b_resp_d = !w_in ? 2'b11 : !w_prot_ok ? 2'b10 : 2'b00;
    w_ok     = commit && w_in && w_prot_ok;
    wr_d     = w_ok ? REG_COUNT'(1) << widx : '0;
    ws_d     = commit ? RESP : (ws_q == RESP && master.b_ready) ? IDLE : ws_q;
    ridx     = IW'(master.ar_addr >> 2);
    r_in     = (master.ar_addr >> 2) < REG_COUNT;
    r_resp_d = !r_in ? 2'b11 : !r_prot_ok ? 2'b10 : 2'b00;
    r_data_d = (r_in && r_prot_ok) ? regs_q[ridx] : 32'h0;
    rs_d     = ar_fire ? RESP : (rs_q == RESP && master.r_ready) ? IDLE : rs_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_q      <= IDLE;
      rs_q      <= IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= '0;
      r_resp_q  <= '0;
      r_data_q  <= '0;
      wr_q      <= '0;
`ifdef AXI_LITE_REG_PROT_CHECK_EN
      aw_priv_q <= 1'b0;
`endif
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      ws_q <= ws_d;
      rs_q <= rs_d;
      wr_q <= wr_d;
      if (aw_fire && !commit) begin
        aw_held_q <= 1'b1;
        aw_addr_q <= master.aw_addr;
`ifdef AXI_LITE_REG_PROT_CHECK_EN
        aw_priv_q <= master.aw_prot[0];
`endif
      end
      if (w_fire && !commit) begin
        w_held_q <= 1'b1;
        w_data_q <= master.w_data;
        w_strb_q <= master.w_strb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        b_resp_q  <= b_resp_d;
      end
      if (ar_fire) begin
        r_data_q <= r_data_d;
        r_resp_q <= r_resp_d;
      end
      for (int k = 0; k < 4; k++)
        if (w_ok && ws[k]) regs_q[widx][8*k +: 8] <= wd[8*k +: 8];
    end
  end
endmodule

// File: doc/axi_lite_reg_slave.md
AXI_LITE_REG_SLAVE -- requirements
Module: axi_lite_reg_slave

Interface
REQ-001 The block SHALL have parameter REG_COUNT, default 8, giving the number of 32-bit registers; it is a power of two in the range 2..64.
REQ-002 The block SHALL have parameter RESET_VALUE, default 32'h0, giving the reset contents of every register.
REQ-003 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 Port master, axi_lite_channel.slave, 32-bit data: the AXI-lite target port driven by an upstream master.
REQ-006 Port reg_q, output, REG_COUNT*32 bits: current register contents; register i occupies bits [32*i+31:32*i].
REQ-007 Port reg_wr, output, REG_COUNT bits: one-cycle pulse per register on each committed write.

Function
REQ-008 The register index SHALL be addr[2 +: log2(REG_COUNT)]; addr[1:0] are ignored.
REQ-009 An address >= REG_COUNT*4 SHALL be out of range, with response DECERR (2'b11); in-range responses SHALL be OKAY (2'b00).
REQ-010 The write path SHALL have two states: IDLE and RESP.
REQ-011 In IDLE: aw_ready = 1 while no address is held; w_ready = 1 while no data is held.
REQ-012 The AW and W handshakes SHALL be accepted independently and in either order; each captured beat is held until its pair arrives.
REQ-013 A write SHALL commit at the clock edge that ends the cycle in which the second of AW/W completes, including when both complete in the same cycle.
REQ-014 At commit, for an in-range write, byte lane k of the target register SHALL update iff w_strb[k] = 1; reg_wr[index] SHALL pulse in the following cycle.
REQ-015 At commit, for an out-of-range write, no register changes and reg_wr stays 0.
REQ-016 At commit the write path SHALL enter RESP: b_valid = 1 with b_resp, aw_ready = 0, w_ready = 0.
REQ-017 In RESP, b_valid and b_resp SHALL stay stable until b_ready = 1; the path then returns to IDLE on the next cycle with the held beats cleared.
REQ-018 The read path SHALL have two states: IDLE (ar_ready = 1) and RESP (ar_ready = 0, r_valid = 1).
REQ-019 An AR handshake SHALL register r_data and r_resp and enter RESP on the same edge, giving 1 cycle of latency.
REQ-020 An out-of-range read SHALL return r_data = 0 with DECERR.
REQ-021 r_data and r_resp SHALL stay stable until r_ready = 1; the read path then returns to IDLE on the next cycle.
REQ-022 A read and a write commit to the same register on the same edge SHALL return the pre-write value.
REQ-023 The read and write paths SHALL be fully independent and SHALL NOT stall each other.
REQ-024 Peak throughput SHALL be one transaction per 2 cycles per path.

Reset
REQ-025 While rst = 1: aw_ready, w_ready, ar_ready, b_valid, r_valid and reg_wr = 0; b_resp, r_resp and r_data = 0; every register = RESET_VALUE.
REQ-026 The first cycle after rst falls, both paths SHALL be in IDLE with the readies at 1.
REQ-027 Reset asserted mid-transaction SHALL discard held beats and pending responses; no partial write is committed.

Configuration
REQ-028 With macro AXI_LITE_REG_PROT_CHECK_EN defined, an AW with aw_prot[0] = 0 (unprivileged) SHALL complete with SLVERR (2'b10) and no register update or reg_wr pulse.
REQ-029 With AXI_LITE_REG_PROT_CHECK_EN defined, an AR with ar_prot[0] = 0 SHALL return r_data = 0 with SLVERR.
REQ-030 With AXI_LITE_REG_PROT_CHECK_EN defined, an out-of-range address SHALL give DECERR, which takes precedence over SLVERR.
REQ-031 Without AXI_LITE_REG_PROT_CHECK_EN, the prot signals SHALL be ignored.

Verification
REQ-032 AW addr 0x4 and W data 0xDEADBEEF, strb 4'hF in the same cycle, b_ready = 1 -> B OKAY 1 cycle later; reg_q[63:32] = 0xDEADBEEF; reg_wr = 8'b0000_0010 for 1 cycle.
REQ-033 W data 0x11223344, strb 4'b0101 three cycles before AW addr 0x8, register initially 0 -> register 2 = 0x00220044; w_ready = 0 while the data is held.
REQ-034 AR addr 0x20 (REG_COUNT = 8) -> r_data = 0, r_resp = 2'b11; a write to 0x20 -> DECERR, reg_q unchanged.
REQ-035 r_ready held 0 for 5 cycles after AR addr 0x4 -> r_valid and r_data stable throughout; ar_ready = 0 until 1 cycle after the r_ready handshake.
REQ-036 rst pulsed after the AW handshake but before W -> no B response; a following full write to the same address behaves as REQ-032.
REQ-037 With AXI_LITE_REG_PROT_CHECK_EN defined, a write to 0x0 with aw_prot = 3'b000 -> B SLVERR, register unchanged; the same write with aw_prot = 3'b001 -> OKAY.
